mips_multicycle_ctrl: RTL

Multi-cycle control FSM for the MIPS core. It sequences a shared datapath (one ALU, one unified instruction/data memory, IR, PC) through fetch, decode, execute, memory and write-back steps for R-type, lw, sw, beq, bne, j and addi. It waits on a memory-ready handshake and keeps a count of retired instructions. It sits between the IR opcode field and the datapath mux/enable inputs.

---
 rtl/mips_multicycle_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multi-cycle MIPS control FSM; MIPS_CTRL_ILLEGAL_TRAP_EN enables the illegal-opcode trap
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             branch_ne,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    output logic             illegal_op,
`endif
    output logic [CNT_W-1:0] instr_retired
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_RD    = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WR    = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        ADDI_WB   = 4'd11,
        TRAP      = 4'd12
`else
        ADDI_WB   = 4'd11
`endif
    } state_t;

    state_t           state_q;
    logic             bne_q;
    logic             is_store_q;
    logic             retire;
    logic [CNT_W-1:0] cnt_q;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    logic             illegal_q;
`endif

    // An instruction retires on the cycle whose edge returns the FSM to FETCH.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB: retire = 1'b1;
            MEM_WR:                              retire = mem_ready;
            default:                             retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            bne_q      <= 1'b0;
            is_store_q <= 1'b0;
            cnt_q      <= '0;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
            illegal_q  <= 1'b0;
`endif
        end else begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, retire};
            case (state_q)
                FETCH:     if (mem_ready) state_q <= DECODE;
                DECODE: begin
                    bne_q      <= (opcode == OP_BNE);
                    is_store_q <= (opcode == OP_SW);
                    case (opcode)
                        OP_LW, OP_SW:   state_q <= MEM_ADDR;
                        OP_R:           state_q <= R_EXEC;
                        OP_BEQ, OP_BNE: state_q <= BRANCH;
                        OP_J:           state_q <= JUMP;
                        OP_ADDI:        state_q <= ADDI_EXEC;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                        default: begin
                            state_q   <= TRAP;
                            illegal_q <= 1'b1;
                        end
`else
                        default:        state_q <= FETCH;
`endif
                    endcase
                end
                MEM_ADDR:  state_q <= is_store_q ? MEM_WR : MEM_RD;
                MEM_RD:    if (mem_ready) state_q <= MEM_WB;
                MEM_WR:    if (mem_ready) state_q <= FETCH;
                R_EXEC:    state_q <= R_WB;
                ADDI_EXEC: state_q <= ADDI_WB;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                TRAP:      state_q <= TRAP;
`endif
                default:   state_q <= FETCH;
            endcase
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE:    alu_src_b = 2'b11;
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                branch_ne     = bne_q;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            ADDI_WB:   reg_write = 1'b1;
            default: begin
            end
        endcase
    end

    assign state         = state_q;
    assign instr_retired = cnt_q;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    assign illegal_op    = illegal_q;
`endif

endmodule
